// File: rtl/comprobador_respuesta.sv
// Checks accepted Respuesta words against ESPERADO, declares lock after UMBRAL matches, counts hits/misses.
// State/counters update one cycle after the accepting edge; Listo drops for exactly one cycle per loss of lock.
module comprobador_respuesta #(
  parameter int unsigned      ANCHO    = 16,
  parameter logic [ANCHO-1:0] ESPERADO = '0,
  parameter int unsigned      UMBRAL   = 4,
  parameter int unsigned      CUENTA_W = 8
) (
  input  logic                Reloj,
  input  logic                Reinicio,
  input  logic [ANCHO-1:0]    Respuesta,
  input  logic                Valido,
  output logic                Listo,
  output logic                Enganchado,
  output logic                Error,
  output logic [CUENTA_W-1:0] Aciertos,
  output logic [CUENTA_W-1:0] Fallos,
  output logic [ANCHO-1:0]    Ultimo
);

  typedef enum logic [1:0] {
    BUSCA      = 2'd0,
    ENGANCHADO = 2'd1,
    FALLA      = 2'd2
  } estado_t;

  localparam logic [3:0]          UMBRAL_R   = 4'(UMBRAL);
  localparam logic [CUENTA_W-1:0] CUENTA_MAX = '1;

  estado_t             estado_q;
  logic [3:0]          racha_q;
  logic                error_q;
  logic [ANCHO-1:0]    ultimo_q;
  logic [CUENTA_W-1:0] aciertos_q, aciertos_d;
  logic [CUENTA_W-1:0] fallos_q, fallos_d;

  logic       acepta;
  logic       coincide;
  logic [3:0] racha_sig;

  // Listo/Enganchado are pure decodes of the state register, so they never glitch.
  assign Listo      = (estado_q != FALLA);
  assign Enganchado = (estado_q == ENGANCHADO);
  assign acepta     = Valido && Listo;
  assign coincide   = (Respuesta == ESPERADO);
  assign racha_sig  = racha_q + 4'd1;

  always_comb begin
    aciertos_d = aciertos_q;
    fallos_d   = fallos_q;
    if (acepta) begin
      if (coincide) begin
        if (aciertos_q != CUENTA_MAX) aciertos_d = aciertos_q + 1'b1;
      end else begin
        if (fallos_q != CUENTA_MAX) fallos_d = fallos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Reloj) begin
    if (Reinicio) begin
      estado_q   <= BUSCA;
      racha_q    <= 4'd0;
      error_q    <= 1'b0;
      ultimo_q   <= '0;
      aciertos_q <= '0;
      fallos_q   <= '0;
    end else begin
      aciertos_q <= aciertos_d;
      fallos_q   <= fallos_d;
      case (estado_q)
        BUSCA: begin
          if (acepta) begin
            if (coincide) begin
              if (racha_sig == UMBRAL_R) begin
                estado_q <= ENGANCHADO;
                racha_q  <= 4'd0;
              end else begin
                racha_q  <= racha_sig;
              end
            end else begin
              racha_q <= 4'd0;
            end
          end
        end
        ENGANCHADO: begin
          if (acepta && !coincide) begin
            estado_q <= FALLA;
            error_q  <= 1'b1;
            // Only the first offender since reset is kept.
            if (!error_q) ultimo_q <= Respuesta;
          end
        end
        FALLA: begin
          estado_q <= BUSCA;
          racha_q  <= 4'd0;
        end
        default: begin
          estado_q <= BUSCA;
          racha_q  <= 4'd0;
        end
      endcase
    end
  end

  assign Error    = error_q;
  assign Ultimo   = ultimo_q;
  assign Aciertos = aciertos_q;
  assign Fallos   = fallos_q;

endmodule

// File: tb/tb_comprobador_respuesta.sv
// Scoreboarded bench for comprobador_respuesta: behavioural model pushes expected status per cycle.
module tb_comprobador_respuesta;

  localparam int unsigned ANCHO    = 16;
  localparam int unsigned CUENTA_W = 8;
  localparam int unsigned UMBRAL   = 4;
  localparam logic [15:0] ESPERADO = 16'h0000;

  logic        Reloj = 1'b0;
  logic        Reinicio;
  logic        Valido;
  logic [15:0] Respuesta;
  logic        Listo, Enganchado, Error;
  logic [7:0]  Aciertos, Fallos;
  logic [15:0] Ultimo;

  comprobador_respuesta #(
    .ANCHO(ANCHO), .ESPERADO(ESPERADO), .UMBRAL(UMBRAL), .CUENTA_W(CUENTA_W)
  ) dut (
    .Reloj(Reloj), .Reinicio(Reinicio), .Respuesta(Respuesta), .Valido(Valido),
    .Listo(Listo), .Enganchado(Enganchado), .Error(Error),
    .Aciertos(Aciertos), .Fallos(Fallos), .Ultimo(Ultimo)
  );

  always #5 Reloj = ~Reloj;

  typedef struct packed {
    logic        enganchado;
    logic        listo;
    logic        error;
    logic [7:0]  aciertos;
    logic [7:0]  fallos;
    logic [15:0] ultimo;
  } obs_t;

  typedef enum int {M_BUSCA, M_ENG, M_FALLA} mst_t;

  obs_t exp_q[$];
  obs_t got, exp_v;
  int   n_cmp = 0;
  int   n_bad = 0;

  mst_t        m_st    = M_BUSCA;
  int          m_racha = 0;
  int          m_ac    = 0;
  int          m_fa    = 0;
  logic        m_err   = 1'b0;
  logic [15:0] m_ult   = 16'h0000;

  function automatic obs_t obs();
    obs_t o;
    o = {Enganchado, Listo, Error, Aciertos, Fallos, Ultimo};
    return o;
  endfunction

  // Drive one cycle, advance the model across the same edge, queue the expectation.
  task automatic step(input logic rst, input logic vld, input logic [15:0] w);
    obs_t e;
    logic acc;
    Reinicio  = rst;
    Valido    = vld;
    Respuesta = w;
    acc = vld && (m_st != M_FALLA);
    if (rst) begin
      m_st = M_BUSCA; m_racha = 0; m_ac = 0; m_fa = 0; m_err = 1'b0; m_ult = 16'h0000;
    end else if (m_st == M_FALLA) begin
      m_st = M_BUSCA; m_racha = 0;
    end else if (acc) begin
      if (w == ESPERADO) begin
        if (m_ac < 255) m_ac++;
        if (m_st == M_BUSCA) begin
          if (m_racha + 1 == int'(UMBRAL)) begin m_st = M_ENG; m_racha = 0; end
          else m_racha++;
        end
      end else begin
        if (m_fa < 255) m_fa++;
        if (m_st == M_ENG) begin
          m_st = M_FALLA;
          if (!m_err) m_ult = w;
          m_err = 1'b1;
        end else begin
          m_racha = 0;
        end
      end
    end
    e.enganchado = (m_st == M_ENG);
    e.listo      = (m_st != M_FALLA);
    e.error      = m_err;
    e.aciertos   = 8'(m_ac);
    e.fallos     = 8'(m_fa);
    e.ultimo     = m_ult;
    exp_q.push_back(e);
    @(posedge Reloj);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 16'h0000);
    got = obs(); exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL reset[0]: got %h want %h", got, exp_v); end
    step(1'b1, 1'b0, 16'h0000);
    got = obs(); exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL reset[1]: got %h want %h", got, exp_v); end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 16'hFFFF);
      got = obs(); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL idle[%0d]: got %h want %h", i, got, exp_v); end
    end
    n_cmp++;
    if (obs() !== 35'h2_0000_0000) begin
      n_bad++; $display("FAIL reset_const: got %h want %h", obs(), 35'h2_0000_0000);
    end
  endtask

  task automatic test_lock();
    step(1'b1, 1'b0, 16'h0000);
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 16'h0000);
      got = obs(); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL lock[%0d]: got %h want %h", i, got, exp_v); end
      n_cmp++;
      if (Enganchado !== (i >= 3)) begin
        n_bad++; $display("FAIL lock_eng[%0d]: got %b want %b", i, Enganchado, (i >= 3));
      end
    end
    n_cmp++;
    if ({Aciertos, Fallos, Error} !== {8'd6, 8'd0, 1'b0}) begin
      n_bad++; $display("FAIL lock_counts: got ac=%0d fa=%0d err=%b want 6 0 0", Aciertos, Fallos, Error);
    end
  endtask

  task automatic test_broken_run();
    logic [15:0] pat [8];
    pat = '{16'h0000, 16'h0000, 16'h0000, 16'h00A5, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    step(1'b1, 1'b0, 16'h0000);
    void'(exp_q.pop_front());
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, pat[i]);
      got = obs(); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL broken[%0d]: got %h want %h", i, got, exp_v); end
      n_cmp++;
      if (Enganchado !== (i == 7)) begin
        n_bad++; $display("FAIL broken_eng[%0d]: got %b want %b", i, Enganchado, (i == 7));
      end
    end
    n_cmp++;
    if ({Fallos, Error, Ultimo} !== {8'd1, 1'b0, 16'h0000}) begin
      n_bad++; $display("FAIL broken_end: got fa=%0d err=%b ult=%h want 1 0 0000", Fallos, Error, Ultimo);
    end
  endtask

  task automatic test_loss();
    logic [15:0] pat [13];
    pat = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'hBEEF, 16'hBEEF,
            16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 16'h0000};
    step(1'b1, 1'b0, 16'h0000);
    void'(exp_q.pop_front());
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b1, pat[i]);
      got = obs(); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL loss[%0d]: got %h want %h", i, got, exp_v); end
      if (i == 4) begin
        n_cmp++;
        if ({Enganchado, Listo, Error, Ultimo} !== {1'b0, 1'b0, 1'b1, 16'h1234}) begin
          n_bad++; $display("FAIL loss_stall: got eng=%b listo=%b err=%b ult=%h want 0 0 1 1234", Enganchado, Listo, Error, Ultimo);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if ({Listo, Fallos} !== {1'b1, 8'd1}) begin
          n_bad++; $display("FAIL loss_held: got listo=%b fa=%0d want 1 1", Listo, Fallos);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if (Fallos !== 8'd2) begin n_bad++; $display("FAIL loss_beef: got fa=%0d want 2", Fallos); end
      end
    end
    n_cmp++;
    if ({Error, Ultimo} !== {1'b1, 16'h1234}) begin
      n_bad++; $display("FAIL loss_ultimo: got err=%b ult=%h want 1 1234", Error, Ultimo);
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 16'h0000);
    void'(exp_q.pop_front());
    for (int i = 0; i < 600; i++) begin
      step(1'b0, 1'b1, (i < 300) ? 16'h0000 : 16'h0F0F);
      got = obs(); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL sat[%0d]: got %h want %h", i, got, exp_v); end
      if (i == 299) begin
        n_cmp++;
        if ({Aciertos, Fallos} !== {8'd255, 8'd0}) begin
          n_bad++; $display("FAIL sat_ac: got ac=%0d fa=%0d want 255 0", Aciertos, Fallos);
        end
      end
    end
    n_cmp++;
    if ({Aciertos, Fallos} !== {8'd255, 8'd255}) begin
      n_bad++; $display("FAIL sat_end: got ac=%0d fa=%0d want 255 255", Aciertos, Fallos);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 16'h0000);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, (i < 4) ? 16'h0000 : 16'hDEAD);
      got = obs(); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL mid_pre[%0d]: got %h want %h", i, got, exp_v); end
    end
    step(1'b1, 1'b1, 16'h0000);
    got = obs(); exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL mid_rst: got %h want %h", got, exp_v); end
    n_cmp++;
    if (obs() !== 35'h2_0000_0000) begin
      n_bad++; $display("FAIL mid_clear: got %h want %h", obs(), 35'h2_0000_0000);
    end
    step(1'b0, 1'b1, 16'h0000);
    got = obs(); exp_v = exp_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL mid_post: got %h want %h", got, exp_v); end
    n_cmp++;
    if ({Enganchado, Aciertos} !== {1'b0, 8'd1}) begin
      n_bad++; $display("FAIL mid_busca: got eng=%b ac=%0d want 0 1", Enganchado, Aciertos);
    end
  endtask

  initial begin
    Reinicio  = 1'b1;
    Valido    = 1'b0;
    Respuesta = 16'h0000;
    #1;
    test_reset();
    test_lock();
    test_broken_run();
    test_loss();
    test_saturation();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
